// File: rtl/csa_sub_8_pipe.sv
// Two-stage carry-select subtractor: stage 1 forms the low difference and both
// upper-half candidates, stage 2 picks the upper half using the low-half borrow.
module csa_sub_half #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] t;

  // A negative result sets the extra top bit, which is the borrow-out.
  assign t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
  assign d    = t[W-1:0];
  assign bout = t[W];
endmodule

module csa_sub_8_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);
  localparam int L = WIDTH / 2;

  // Slot 0: low half; slot 1: upper half, borrow-in 0; slot 2: upper half, borrow-in 1.
  logic [2:0][L-1:0] hx, hy, hd;
  logic [2:0]        hbin, hbout;

  assign hx   = {a[WIDTH-1:L], a[WIDTH-1:L], a[L-1:0]};
  assign hy   = {b[WIDTH-1:L], b[WIDTH-1:L], b[L-1:0]};
  assign hbin = 3'b100;

  for (genvar i = 0; i < 3; i++) begin : g_half
    csa_sub_half #(.W(L)) u_half (
      .x    (hx[i]),
      .y    (hy[i]),
      .bin  (hbin[i]),
      .d    (hd[i]),
      .bout (hbout[i])
    );
  end

  logic         s1_valid, s2_valid;
  logic [L-1:0] s1_lo, s1_h0, s1_h1;
  logic         s1_bl, s1_bh0, s1_bh1, s1_amsb, s1_bmsb;
  logic         adv1, adv2;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = !rst && adv1;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_h0    <= '0;
      s1_h1    <= '0;
      s1_bl    <= 1'b0;
      s1_bh0   <= 1'b0;
      s1_bh1   <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (in_valid && adv1) begin
        s1_lo   <= hd[0];
        s1_bl   <= hbout[0];
        s1_h0   <= hd[1];
        s1_bh0  <= hbout[1];
        s1_h1   <= hd[2];
        s1_bh1  <= hbout[2];
        s1_amsb <= a[WIDTH-1];
        s1_bmsb <= b[WIDTH-1];
      end
    end
  end

  logic [WIDTH-1:0] d_next;
  logic             b_next;

  assign d_next = {(s1_bl ? s1_h1 : s1_h0), s1_lo};
  assign b_next = s1_bl ? s1_bh1 : s1_bh0;

  // Output registers only move on a stage-2 advance, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        diff     <= d_next;
        borrow   <= b_next;
        overflow <= (s1_amsb != s1_bmsb) && (d_next[WIDTH-1] != s1_amsb);
      end
    end
  end
endmodule

// File: tb/tb_csa_sub_8_pipe.sv
// Bench for csa_sub_8_pipe: directed vector table, backpressure and reset
// sequences, then every (a,b) pair under random valid/ready, all via a scoreboard.
module tb_csa_sub_8_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, diff;
  logic       borrow, overflow;

  csa_sub_8_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_out   = 0;
  logic [9:0] sb[$];
  logic [9:0] cur_exp;
  logic [9:0] held_q;
  logic       prev_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x - y;
    return {d, x < y, (x[7] != y[7]) && (d[7] != x[7])};
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out: got %0h, expected no output", {diff, borrow, overflow});
      end else begin
        chk("sb_result", {22'd0, diff, borrow, overflow}, {22'd0, sb.pop_front()});
      end
    end
    if (in_valid && in_ready) sb.push_back(cur_exp);
    if (prev_stall) chk("hold_stable", {22'd0, diff, borrow, overflow}, {22'd0, held_q});
    prev_stall = out_valid && !out_ready && !rst;
    held_q     = {diff, borrow, overflow};
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb);
    int w;
    w        = 0;
    a        = ta;
    b        = tb;
    cur_exp  = model(ta, tb);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    int         lat;
    int         n0;
    logic [9:0] held;

    tbl[0] = '{8'h50, 8'h23, 8'h2D, 1'b0, 1'b0};
    tbl[1] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    tbl[7] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cur_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", {diff, borrow, overflow}, 0);
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;

    // Directed vectors with latency check
    for (int i = 0; i < 8; i++) begin
      a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
      cur_exp = {tbl[i].d, tbl[i].br, tbl[i].ov};
      @(negedge clk);
      chk("vec_accept", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 6) begin
        @(negedge clk);
        lat++;
      end
      chk("vec_latency", lat, 2);
      chk("vec_diff", diff, tbl[i].d);
      chk("vec_borrow", borrow, tbl[i].br);
      chk("vec_overflow", overflow, tbl[i].ov);
      @(posedge clk);
      #1;
    end

    // Backpressure: two results fill the pipe, third input is refused
    out_ready = 1'b0;
    send(8'h40, 8'h11);
    send(8'h03, 8'h09);
    a = 8'h90; b = 8'h20; cur_exp = model(8'h90, 8'h20); in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    held = {diff, borrow, overflow};
    chk("bp_head", held, model(8'h40, 8'h11));
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold", {diff, borrow, overflow}, held);
      chk("bp_in_ready_held", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1; n0 = n_out;
    @(negedge clk);
    chk("bp_recover", in_ready, 1);
    @(posedge clk);
    #1 a = 8'h05; b = 8'hF0; cur_exp = model(8'h05, 8'hF0);
    @(negedge clk);
    chk("bp_accept4", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("bp_throughput", n_out - n0, 4);
    chk("bp_drained", sb.size(), 0);
    @(posedge clk);
    #1;

    // Reset with two results in flight
    out_ready = 1'b0;
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    rst = 1'b1; a = 8'h55; b = 8'h66; cur_exp = model(8'h55, 8'h66); in_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sb.delete(); n0 = n_out;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_outputs", {diff, borrow, overflow}, 0);
    chk("rst_mid_in_ready_back", in_ready, 1);
    repeat (5) @(negedge clk);
    #1 chk("rst_no_stale", n_out - n0, 0);
    @(posedge clk);
    #1;

    // Exhaustive with random valid/ready
    for (int i = 0; i < 65536; ) begin
      logic [15:0] idx;
      idx = i[15:0];
      out_ready = ($urandom_range(31) != 0);
      if ($urandom_range(63) != 0) begin
        a = idx[15:8]; b = idx[7:0]; cur_exp = model(idx[15:8], idx[7:0]); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    #1 chk("exh_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
